// File: rtl/mem_lsu_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave).
// Request/grant handshake followed by a separate response/acknowledge strobe.
interface mem_lsu_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: issues one bus transaction per load/store, stalls the
// pipeline until the response, aligns/extends load data, flags misalignment and timeouts.
module mem_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_stall,
  output logic [31:0] read_data,
  output logic        lsu_misaligned,
  output logic        lsu_bus_error,
  mem_lsu_if.master   dmem
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT);

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        err_reg, err_next;
  logic [31:0] read_data_reg, read_data_next;
  logic [31:0] addr_reg, wdata_reg;
  logic [3:0]  wstrb_reg;
  logic        we_reg;
  logic [2:0]  funct3_reg;
  logic [1:0]  off_reg;

  logic        start, fault, load_regs, timeout_hit;
  logic [3:0]  lane_wstrb;
  logic [31:0] lane_wdata, shifted, aligned;

  assign start = mem_valid & (mem_read | mem_write);

  // mem_read wins when both are set, so "store" means not a load
  assign fault = ((mem_funct3[1:0] == 2'b01) & mem_addr[0])
               | ((mem_funct3[1:0] == 2'b10) & (mem_addr[1:0] != 2'b00))
               | (mem_read & ((mem_funct3 == 3'b011) | (mem_funct3[2:1] == 2'b11)))
               | (~mem_read & (mem_funct3 > 3'b010));

  always_comb begin
    lane_wdata = mem_wdata;
    lane_wstrb = 4'b1111;
    case (mem_funct3[1:0])
      2'b00: begin
        lane_wdata = {4{mem_wdata[7:0]}};
        lane_wstrb = 4'b0001 << mem_addr[1:0];
      end
      2'b01: begin
        lane_wdata = {2{mem_wdata[15:0]}};
        lane_wstrb = 4'b0011 << mem_addr[1:0];
      end
      default: ;
    endcase
    if (mem_read) lane_wstrb = 4'b0000;
  end

  assign shifted = dmem.dmem_rdata >> {off_reg, 3'b000};

  always_comb begin
    case (funct3_reg)
      3'b000:  aligned = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  aligned = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  aligned = {24'd0, shifted[7:0]};
      3'b101:  aligned = {16'd0, shifted[15:0]};
      default: aligned = shifted;
    endcase
  end

  // The cycle being evaluated is the (cnt_reg+1)-th cycle spent in REQ+RESP
  assign timeout_hit = ({1'b0, cnt_reg} + 9'd1) >= TIMEOUT_LIM;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    err_next       = err_reg;
    read_data_next = read_data_reg;
    load_regs      = 1'b0;
    mem_stall      = 1'b0;
    lsu_misaligned = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (fault) begin
            lsu_misaligned = 1'b1;
            read_data_next = 32'd0;
          end else begin
            mem_stall  = 1'b1;
            load_regs  = 1'b1;
            cnt_next   = 8'd0;
            err_next   = 1'b0;
            state_next = REQ;
          end
        end
      end
      REQ: begin
        mem_stall = 1'b1;
        cnt_next  = cnt_reg + 8'd1;
        if (dmem.dmem_gnt) begin
          state_next = RESP;
        end else if (timeout_hit) begin
          state_next     = DONE;
          err_next       = 1'b1;
          read_data_next = 32'd0;
        end
      end
      RESP: begin
        mem_stall = 1'b1;
        cnt_next  = cnt_reg + 8'd1;
        if (dmem.dmem_rvalid) begin
          state_next     = DONE;
          read_data_next = we_reg ? 32'd0 : aligned;
        end else if (timeout_hit) begin
          state_next     = DONE;
          err_next       = 1'b1;
          read_data_next = 32'd0;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= 8'd0;
      err_reg       <= 1'b0;
      read_data_reg <= 32'd0;
      addr_reg      <= 32'd0;
      wdata_reg     <= 32'd0;
      wstrb_reg     <= 4'd0;
      we_reg        <= 1'b0;
      funct3_reg    <= 3'd0;
      off_reg       <= 2'd0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      err_reg       <= err_next;
      read_data_reg <= read_data_next;
      if (load_regs) begin
        addr_reg   <= {mem_addr[31:2], 2'b00};
        wdata_reg  <= lane_wdata;
        wstrb_reg  <= lane_wstrb;
        we_reg     <= ~mem_read;
        funct3_reg <= mem_funct3;
        off_reg    <= mem_addr[1:0];
      end
    end
  end

  assign read_data       = read_data_reg;
  assign lsu_bus_error   = (state_reg == DONE) & err_reg;
  assign dmem.dmem_req   = (state_reg == REQ);
  assign dmem.dmem_we    = we_reg;
  assign dmem.dmem_addr  = addr_reg;
  assign dmem.dmem_wstrb = wstrb_reg;
  assign dmem.dmem_wdata = wdata_reg;
endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed vector table, randomized accesses against a reference
// model, and hand sequences for reset mid-transaction and bus timeout (TIMEOUT=4 copy).
module tb_mem_lsu;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic mem_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  mem_funct3 = 3'd0;
  logic [31:0] mem_addr = 32'd0, mem_wdata = 32'd0;
  logic        stall1, mis1, berr1, stall2, mis2, berr2;
  logic [31:0] rd1, rd2;
  logic        sel = 1'b0, gnt_drv = 1'b0, rv_drv = 1'b0;
  logic [31:0] rdata_drv = 32'd0;

  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mem_lsu_if bus1();
  mem_lsu_if bus2();
  assign bus1.dmem_gnt    = gnt_drv & ~sel;
  assign bus1.dmem_rvalid = rv_drv & ~sel;
  assign bus1.dmem_rdata  = rdata_drv;
  assign bus2.dmem_gnt    = gnt_drv & sel;
  assign bus2.dmem_rvalid = rv_drv & sel;
  assign bus2.dmem_rdata  = rdata_drv;

  mem_lsu dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_read(mem_read),
    .mem_write(mem_write), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_stall(stall1), .read_data(rd1),
    .lsu_misaligned(mis1), .lsu_bus_error(berr1), .dmem(bus1)
  );

  mem_lsu #(.TIMEOUT(4)) dut_to (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_read(mem_read),
    .mem_write(mem_write), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_stall(stall2), .read_data(rd2),
    .lsu_misaligned(mis2), .lsu_bus_error(berr2), .dmem(bus2)
  );

  logic        o_stall, o_mis, o_berr, o_req, o_we;
  logic [31:0] o_rd, o_addr, o_wd;
  logic [3:0]  o_strb;
  assign o_stall = sel ? stall2 : stall1;
  assign o_mis   = sel ? mis2 : mis1;
  assign o_berr  = sel ? berr2 : berr1;
  assign o_rd    = sel ? rd2 : rd1;
  assign o_req   = sel ? bus2.dmem_req : bus1.dmem_req;
  assign o_we    = sel ? bus2.dmem_we : bus1.dmem_we;
  assign o_addr  = sel ? bus2.dmem_addr : bus1.dmem_addr;
  assign o_wd    = sel ? bus2.dmem_wdata : bus1.dmem_wdata;
  assign o_strb  = sel ? bus2.dmem_wstrb : bus1.dmem_wstrb;

  // results of the last run_access
  int          r_stall;
  logic        r_mis, r_berr, r_we, r_stable, r_req, r_tout;
  logic [31:0] r_rd, r_addr, r_wd;
  logic [3:0]  r_strb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int gdly, input int rdly);
    int   k, req_cyc, resp_cyc;
    logic in_resp, done, granted;
    r_stall = 0; r_mis = 0; r_berr = 0; r_rd = '0; r_addr = '0; r_wd = '0;
    r_strb = '0; r_we = 0; r_stable = 1; r_req = 0; r_tout = 0;
    @(negedge clk);
    mem_valid = 1; mem_read = rd; mem_write = wr; mem_funct3 = f3;
    mem_addr = addr; mem_wdata = wdata; rdata_drv = rdata; gnt_drv = 0; rv_drv = 0;
    #1;
    r_mis = o_mis;
    r_stall = o_stall ? 1 : 0;
    if (o_mis) begin
      @(posedge clk); #1;
      mem_valid = 0;
      #1;
      r_rd = o_rd; r_req = o_req;
    end else begin
      req_cyc = 0; resp_cyc = 0; in_resp = 0; done = 0; k = 0;
      while (!done && k < 300) begin
        @(negedge clk);
        gnt_drv = 0; rv_drv = 0; granted = 0;
        if (o_req) begin
          if (!r_req) begin
            r_req = 1; r_addr = o_addr; r_wd = o_wd; r_strb = o_strb; r_we = o_we;
          end else if (o_addr !== r_addr || o_wd !== r_wd || o_strb !== r_strb || o_we !== r_we) begin
            r_stable = 0;
          end
          granted = (req_cyc >= gdly);
          gnt_drv = granted;
          req_cyc++;
        end else if (in_resp) begin
          rv_drv = (resp_cyc >= rdly);
          resp_cyc++;
        end
        #1;
        if (!o_stall) begin
          done = 1; r_rd = o_rd; r_berr = o_berr;
          mem_valid = 0; gnt_drv = 0; rv_drv = 0;
        end else begin
          r_stall++;
          if (granted) in_resp = 1;
        end
        k++;
      end
      r_tout = !done;
    end
  endtask

  // Reference: architectural rules expressed with arithmetic on byte offsets
  function automatic void model(input logic rd, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                output logic mis, output logic [31:0] erd,
                                output logic [3:0] strb, output logic [31:0] wd);
    int off;
    logic [31:0] val, part;
    off = int'(addr % 32'd4);
    mis = 0; erd = 0; strb = 0; wd = 0;
    if ((f3 % 4) == 1 && (addr % 2) != 0) mis = 1;
    if ((f3 % 4) == 2 && off != 0) mis = 1;
    if (rd && (f3 == 3 || f3 == 6 || f3 == 7)) mis = 1;
    if (!rd && f3 > 2) mis = 1;
    if (mis) return;
    if (rd) begin
      val = rdata >> (8 * off);
      case (f3)
        3'd0: begin part = val % 256;   erd = (part >= 128) ? part - 256 : part; end
        3'd1: begin part = val % 65536; erd = (part >= 32768) ? part - 65536 : part; end
        3'd4: erd = val % 256;
        3'd5: erd = val % 65536;
        default: erd = val;
      endcase
    end else begin
      case (f3)
        3'd0: begin wd = (wdata % 256) * 32'h0101_0101;   strb = 4'(1 << off); end
        3'd1: begin wd = (wdata % 65536) * 32'h0001_0001; strb = 4'(3 << off); end
        default: begin wd = wdata; strb = 4'hF; end
      endcase
    end
  endfunction

  task automatic compare_all(input string tag, input logic rd, input logic [2:0] f3,
                             input logic [31:0] addr, input logic e_mis, input logic [31:0] e_rd,
                             input logic [3:0] e_strb, input logic [31:0] e_wd,
                             input int e_stall, input logic e_berr);
    $display("txn %s rd=%0b f3=%0d addr=%h stall=%0d read_data=%h mis=%0b berr=%0b",
             tag, rd, f3, addr, r_stall, r_rd, r_mis, r_berr);
    chk({tag, " misaligned"}, 32'(r_mis), 32'(e_mis));
    chk({tag, " stall_cycles"}, r_stall, e_stall);
    chk({tag, " read_data"}, r_rd, e_rd);
    chk({tag, " bus_error"}, 32'(r_berr), 32'(e_berr));
    chk({tag, " completed"}, 32'(r_tout), 32'd0);
    chk({tag, " req_seen"}, 32'(r_req), 32'(!e_mis));
    if (!e_mis) begin
      chk({tag, " dmem_addr"}, r_addr, addr & 32'hFFFF_FFFC);
      chk({tag, " dmem_we"}, 32'(r_we), 32'(!rd));
      chk({tag, " dmem_wstrb"}, 32'(r_strb), 32'(e_strb));
      if (!rd) chk({tag, " dmem_wdata"}, r_wd, e_wd);
      chk({tag, " req_stable"}, 32'(r_stable), 32'd1);
    end
  endtask

  typedef struct {
    logic rd, wr; logic [2:0] f3; logic [31:0] addr, wdata, rdata; int gdly, rdly;
    logic e_mis; logic [31:0] e_rd; logic [3:0] e_strb; logic [31:0] e_wd; int e_stall;
  } vec_t;
  vec_t vecs [15];

  logic        t_rd, t_wr, t_mis;
  logic [2:0]  t_f3;
  logic [31:0] t_a, t_wd, t_rdat, t_u, t_erd, t_ewd;
  logic [3:0]  t_strb;
  int          t_g, t_r;
  logic [2:0]  lf3 [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1,0,3'd0,32'h1003,32'h0,32'h80FF1234,0,0, 0,32'hFFFFFF80,4'h0,32'h0,3};
    vecs[1]  = '{1,0,3'd5,32'h2002,32'h0,32'hBEEF0000,0,0, 0,32'h0000BEEF,4'h0,32'h0,3};
    vecs[2]  = '{0,1,3'd1,32'h3002,32'h1234ABCD,32'h0,5,0, 0,32'h0,4'hC,32'hABCDABCD,8};
    vecs[3]  = '{0,1,3'd0,32'h5001,32'hAA550077,32'h0,1,2, 0,32'h0,4'h2,32'h77777777,6};
    vecs[4]  = '{1,0,3'd2,32'h9000,32'h0,32'hCAFEF00D,0,0, 0,32'hCAFEF00D,4'h0,32'h0,3};
    vecs[5]  = '{1,0,3'd2,32'h4001,32'h0,32'h0,0,0, 1,32'h0,4'h0,32'h0,0};
    vecs[6]  = '{1,0,3'd4,32'h8002,32'h0,32'h00AB0000,0,0, 0,32'h000000AB,4'h0,32'h0,3};
    vecs[7]  = '{1,0,3'd3,32'hA000,32'h0,32'h0,0,0, 1,32'h0,4'h0,32'h0,0};
    vecs[8]  = '{0,1,3'd2,32'h6000,32'hDEADBEEF,32'h0,0,3, 0,32'h0,4'hF,32'hDEADBEEF,6};
    vecs[9]  = '{1,0,3'd1,32'h7000,32'h0,32'h12348001,2,1, 0,32'hFFFF8001,4'h0,32'h0,6};
    vecs[10] = '{0,1,3'd4,32'hB000,32'h0,32'h0,0,0, 1,32'h0,4'h0,32'h0,0};
    vecs[11] = '{1,0,3'd0,32'h8001,32'h0,32'h12347F56,0,0, 0,32'h0000007F,4'h0,32'h0,3};
    vecs[12] = '{1,1,3'd2,32'hC004,32'h55555555,32'h01020304,0,0, 0,32'h01020304,4'h0,32'h0,3};
    vecs[13] = '{0,1,3'd1,32'hD001,32'h0,32'h0,0,0, 1,32'h0,4'h0,32'h0,0};
    vecs[14] = '{1,0,3'd1,32'hD003,32'h0,32'h0,0,0, 1,32'h0,4'h0,32'h0,0};
    lf3[0] = 3'd0; lf3[1] = 3'd1; lf3[2] = 3'd2; lf3[3] = 3'd4; lf3[4] = 3'd5;

    // reset state
    @(negedge clk); @(negedge clk);
    chk("reset dmem_req", 32'(bus1.dmem_req), 32'd0);
    chk("reset mem_stall", 32'(stall1), 32'd0);
    chk("reset read_data", rd1, 32'd0);
    chk("reset dmem_wstrb", 32'(bus1.dmem_wstrb), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      run_access(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                 vecs[i].rdata, vecs[i].gdly, vecs[i].rdly);
      compare_all($sformatf("vec%0d", i), vecs[i].rd, vecs[i].f3, vecs[i].addr, vecs[i].e_mis,
                  vecs[i].e_rd, vecs[i].e_strb, vecs[i].e_wd, vecs[i].e_stall, 1'b0);
    end

    for (int i = 0; i < 60; i++) begin
      t_u = $urandom;
      t_rd = t_u[0];
      t_wr = t_rd ? t_u[1] : 1'b1;
      if (t_u[7:5] != 3'd0) t_f3 = t_rd ? lf3[$urandom % 5] : 3'($urandom % 3);
      else t_f3 = 3'($urandom % 8);
      t_a = $urandom;
      if (t_u[8]) t_a[1:0] = 2'b00;
      t_wd = $urandom; t_rdat = $urandom;
      t_g = int'($urandom % 4); t_r = int'($urandom % 4);
      model(t_rd, t_f3, t_a, t_wd, t_rdat, t_mis, t_erd, t_strb, t_ewd);
      run_access(t_rd, t_wr, t_f3, t_a, t_wd, t_rdat, t_g, t_r);
      compare_all($sformatf("rnd%0d", i), t_rd, t_f3, t_a, t_mis, t_erd, t_strb, t_ewd,
                  t_mis ? 0 : 3 + t_g + t_r, 1'b0);
    end

    // reset while in REQ drops dmem_req at once
    run_access(1, 0, 3'd2, 32'h4440, 32'h0, 32'h5A5A1234, 0, 0);
    compare_all("pre_rst", 1, 3'd2, 32'h4440, 0, 32'h5A5A1234, 4'h0, 32'h0, 3, 1'b0);
    @(negedge clk);
    mem_valid = 1; mem_read = 1; mem_write = 0; mem_funct3 = 3'd2; mem_addr = 32'h4444;
    @(negedge clk);
    chk("rst_req in REQ", 32'(bus1.dmem_req), 32'd1);
    #2; reset = 1'b0; mem_valid = 0; #1;
    chk("rst_req dmem_req", 32'(bus1.dmem_req), 32'd0);
    @(negedge clk); reset = 1'b1;

    // reset while in RESP
    @(negedge clk);
    mem_valid = 1; mem_read = 1; mem_write = 0; mem_funct3 = 3'd2; mem_addr = 32'h4448;
    @(negedge clk); gnt_drv = 1;
    @(negedge clk); gnt_drv = 0;
    chk("rst_resp stall", 32'(stall1), 32'd1);
    #2; reset = 1'b0; mem_valid = 0; #1;
    chk("rst_resp mem_stall", 32'(stall1), 32'd0);
    chk("rst_resp dmem_req", 32'(bus1.dmem_req), 32'd0);
    chk("rst_resp dmem_addr", bus1.dmem_addr, 32'd0);
    chk("rst_resp bus_error", 32'(berr1), 32'd0);
    @(negedge clk); rv_drv = 1;
    @(negedge clk); rv_drv = 0; reset = 1'b1;
    chk("rst_resp read_data", rd1, 32'd0);
    run_access(1, 0, 3'd2, 32'h444C, 32'h0, 32'h0BADF00D, 0, 0);
    compare_all("post_rst", 1, 3'd2, 32'h444C, 0, 32'h0BADF00D, 4'h0, 32'h0, 3, 1'b0);

    // timeout on the TIMEOUT=4 instance
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1; sel = 1'b1;
    run_access(1, 0, 3'd2, 32'h100, 32'h0, 32'h11223344, 0, 0);
    compare_all("to_ok", 1, 3'd2, 32'h100, 0, 32'h11223344, 4'h0, 32'h0, 3, 1'b0);
    run_access(1, 0, 3'd2, 32'h104, 32'h0, 32'h99999999, 0, 100);
    compare_all("to_norv", 1, 3'd2, 32'h104, 0, 32'h0, 4'h0, 32'h0, 5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); rv_drv = 1; gnt_drv = 1; #1;
      chk($sformatf("late_rv%0d dmem_req", i), 32'(o_req), 32'd0);
      chk($sformatf("late_rv%0d stall", i), 32'(o_stall), 32'd0);
      chk($sformatf("late_rv%0d bus_error", i), 32'(o_berr), 32'd0);
      chk($sformatf("late_rv%0d read_data", i), o_rd, 32'd0);
    end
    rv_drv = 0; gnt_drv = 0;
    run_access(0, 1, 3'd2, 32'h108, 32'h0F0F0F0F, 32'h0, 1, 0);
    compare_all("to_nognt_ok", 0, 3'd2, 32'h108, 0, 32'h0, 4'hF, 32'h0F0F0F0F, 4, 1'b0);
    run_access(1, 0, 3'd2, 32'h10C, 32'h0, 32'h77777777, 100, 0);
    compare_all("to_nognt", 1, 3'd2, 32'h10C, 0, 32'h0, 4'h0, 32'h0, 5, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit for the MEM stage. It turns a MEM-stage load or store into a transaction on the data-memory bus and stalls the pipeline until the response arrives. For loads it aligns and sign- or zero-extends the returned word into `read_data`, which the MEM/WB register captures. It also detects misaligned accesses and bus timeouts.

## Interface
- `TIMEOUT`, default 255: cycles spent in REQ+RESP before the access is aborted with a bus error; legal range 1–255.
- `clk` in 1: the only clock, rising-edge.
- `reset` in 1: asynchronous, active-low.
- `mem_valid` in 1: the MEM stage holds a valid instruction.
- `mem_read` in 1: load. Has priority over `mem_write` if both are set.
- `mem_write` in 1: store.
- `mem_funct3` in 3: RV32 size and sign. 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- `mem_addr` in 32: byte address.
- `mem_wdata` in 32: store data.
- `mem_stall` out 1: holds IF through MEM.
- `read_data` out 32: aligned load result.
- `lsu_misaligned` out 1: one-cycle pulse for a misaligned access or illegal funct3.
- `lsu_bus_error` out 1: one-cycle pulse on timeout.
- `dmem_req` out 1: bus request.
- `dmem_we` out 1: bus write enable.
- `dmem_addr` out 32: word address, `{mem_addr[31:2],2'b00}`.
- `dmem_wstrb` out 4: byte strobes.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_gnt` in 1: the request is accepted in a cycle where `dmem_req` and `dmem_gnt` are both high.
- `dmem_rvalid` in 1: response or write acknowledge.
- `dmem_rdata` in 32: read response data.

## Operation
- The FSM has four states: IDLE, REQ, RESP, DONE.
- Start condition, evaluated in IDLE: `start = mem_valid & (mem_read | mem_write)`.
- Fault condition, evaluated in IDLE, is any of:
  - a halfword access with `addr[0]` = 1;
  - a word access with `addr[1:0]` ≠ 0;
  - a load whose funct3 is 011, 110 or 111;
  - a store whose funct3 is greater than 010.
- IDLE with start and a fault:
  - `lsu_misaligned`=1 combinationally, `mem_stall`=0, no bus activity.
  - Stay in IDLE; `read_data` is cleared to 0 at the clock edge.
- IDLE with start and no fault:
  - Register `dmem_addr`, `dmem_we`, `dmem_wstrb`, `dmem_wdata`, funct3 and `addr[1:0]`; go to REQ.
  - Clear the timeout counter.
- REQ: `dmem_req`=1. `dmem_gnt`=1 moves to RESP.
- RESP: `dmem_req`=0. `dmem_rvalid`=1 moves to DONE and registers `read_data`:
  - load: aligned, extended data;
  - store: 0.
- DONE: `mem_stall`=0 so the instruction advances and MEM/WB captures `read_data`; return to IDLE.
- `mem_stall` = (IDLE & start & no fault) | REQ | RESP.
- Timeout:
  - The 8-bit counter increments every REQ/RESP cycle.
  - When it reaches `TIMEOUT` with no gnt/rvalid, go to DONE with `lsu_bus_error`=1 during DONE and `read_data`=0.
  - `dmem_req` drops.
- `dmem_rvalid` or `dmem_gnt` seen in IDLE or DONE is ignored.
- Store lanes:
  - SB: `wdata = {4{wdata[7:0]}}`, `wstrb = 4'b0001 << addr[1:0]`.
  - SH: `wdata = {2{wdata[15:0]}}`, `wstrb = 4'b0011 << addr[1:0]`.
  - SW: `wstrb = 4'b1111`.
  - Loads: `wstrb = 0`.
- Load align: `shifted = dmem_rdata >> (8*addr[1:0])`.
  - LB/LH sign-extend bit 7 or bit 15.
  - LBU/LHU zero-extend.
  - LW passes the full word.

## Timing
- Reset (low): asynchronous; state=IDLE; all registered outputs = 0.
  - `dmem_req` falls immediately even mid-transaction.
  - The transaction is abandoned; no stall or error is produced.
- Minimum load/store occupancy, with gnt in the first REQ cycle and rvalid in the first RESP cycle:
  - cycle 0 IDLE (stall), cycle 1 REQ, cycle 2 RESP, cycle 3 DONE.
  - 3 stall cycles; `read_data` is valid in cycle 3.
- `dmem_req` and all `dmem_*` outputs are registered and stay stable throughout REQ.
- `rvalid` in the same cycle as `gnt` is not accepted; rvalid is required no earlier than the cycle after gnt.
- A new access may start in the IDLE cycle immediately after DONE, giving back-to-back operation with 4 cycles per access.
- Timeout after `TIMEOUT` cycles in REQ+RESP; `lsu_bus_error` asserts in the following DONE cycle.

## Test plan
- LB at 0x1003 with `dmem_rdata`=0x80FF_1234, gnt and rvalid immediate:
  - `dmem_addr`=0x1000, `wstrb`=0;
  - stall high for 3 cycles; `read_data`=0xFFFF_FF80 in DONE.
- LHU at 0x2002 with rdata=0xBEEF_0000 → `read_data`=0x0000_BEEF.
- SH at 0x3002 with wdata=0x1234_ABCD, gnt delayed 5 cycles:
  - `dmem_wdata`=0xABCD_ABCD, `wstrb`=4'b1100, held stable across the wait;
  - `read_data`=0 after ack.
- LW at 0x4001 → `lsu_misaligned` pulse, `mem_stall`=0, `dmem_req` never rises, `read_data`=0.
- `TIMEOUT`=4, gnt given but rvalid never given:
  - DONE after 4 REQ+RESP cycles with `lsu_bus_error`=1 and `read_data`=0;
  - a late rvalid in IDLE has no effect.
- `reset` low during RESP → immediately state=IDLE, all outputs 0; the next LW after reset completes normally.
